voice_param_writer: RTL

VOICE_PARAM_WRITER -- requirements
Module: voice_param_writer

---
 rtl/voice_param_writer_pkg.sv | 39 +++
 rtl/voice_param_writer_phase_rom.sv | 21 ++
 rtl/voice_param_writer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/voice_param_writer_pkg.sv
// Shared definitions for the voice parameter writer: FSM states, RAM word
// layout and the note-to-phase-increment table builder.
package voice_param_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_PEND   = 3'd3,
        ST_WRITE  = 3'd4
    } wr_state_t;

    // Parameter RAM word: {wave_select, delta_phase}
    localparam int unsigned WAVE_MSB = 35;
    localparam int unsigned WAVE_LSB = 32;
    localparam int unsigned DPHASE_W = 32;
    localparam int unsigned WORD_W   = WAVE_MSB + 1;

    // Oscillator sample rate and tuning reference (A4 = note 69 = 440 Hz)
    localparam int unsigned SAMPLE_RATE_HZ = 48000;
    localparam int unsigned A4_NOTE        = 69;
    localparam real         A4_FREQ_HZ     = 440.0;

    typedef logic [127:0][DPHASE_W-1:0] phase_table_t;

    // delta_phase = round(f_note * 2^32 / Fs) for every MIDI note
    function automatic phase_table_t build_phase_table();
        phase_table_t t;
        real          f;
        real          d;
        for (int n = 0; n < 128; n++) begin
            f    = A4_FREQ_HZ * (2.0 ** ((real'(n) - real'(A4_NOTE)) / 12.0));
            d    = f * 4294967296.0 / real'(SAMPLE_RATE_HZ);
            t[n] = DPHASE_W'($rtoi(d + 0.5));
        end
        return t;
    endfunction

endpackage

// File: rtl/voice_param_writer_phase_rom.sv
// Note-number to phase-increment ROM, 128 x 32, one-cycle synchronous read.
module note_phase_rom
    import voice_param_writer_pkg::*;
(
    input  logic                i_clk,
    input  logic [6:0]          i_note,
    output logic [DPHASE_W-1:0] o_delta_phase
);

    localparam phase_table_t PHASE_TABLE = build_phase_table();

    logic [DPHASE_W-1:0] r_data;

    // Registered read; no reset so the table can map onto block ROM
    always_ff @(posedge i_clk) begin
        r_data <= PHASE_TABLE[i_note];
    end

    assign o_delta_phase = r_data;

endmodule

// File: rtl/voice_param_writer.sv
// Voice allocator: takes MIDI note events, finds a voice by linear scan,
// looks up the phase increment and writes the voice parameter word into
// the sequencer's parameter RAM when the sequencer grants an update slot.
module voice_param_writer
    import voice_param_writer_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned ADDR_W     = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_note_on,
    input  logic [6:0]        ev_note,
    input  logic [3:0]        ev_wave,
    input  logic              upd_grant,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_data,
    output logic              overflow
);

    localparam int unsigned       VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    wr_state_t r_state;
    wr_state_t w_next;

    logic              r_note_on;
    logic [6:0]        r_note;
    logic [3:0]        r_wave;
    logic [VIDX_W-1:0] r_idx;
    logic [VIDX_W-1:0] r_sel;
    logic [VIDX_W-1:0] r_free;
    logic              r_have_free;

    logic [NUM_VOICES-1:0] r_busy;
    logic [6:0]            r_vnote [NUM_VOICES];

    logic [ADDR_W-1:0]   r_ram_address;
    logic [WORD_W-1:0]   r_ram_data;
    logic                r_overflow;

    logic [DPHASE_W-1:0] w_rom_data;
    logic [WORD_W-1:0]   w_word;
    logic                w_accept;
    logic                w_cur_busy;
    logic                w_cur_match;
    logic                w_last;
    logic                w_hit_free;

    note_phase_rom u_rom (
        .i_clk         (clk),
        .i_note        (r_note),
        .o_delta_phase (w_rom_data)
    );

    assign w_accept    = ev_valid && ev_ready;
    assign w_cur_busy  = r_busy[r_idx];
    assign w_cur_match = w_cur_busy && (r_vnote[r_idx] == r_note);
    assign w_last      = (r_idx == LAST_IDX);
    // A note-on has somewhere to go at the end of the scan if a free voice
    // was seen earlier or the voice being examined now is free.
    assign w_hit_free  = r_note_on && (r_have_free || !w_cur_busy);

    // Assemble the RAM word; note-off writes silence
    always_comb begin
        w_word = '0;
        if (r_note_on) begin
            w_word[WAVE_MSB:WAVE_LSB] = r_wave;
            w_word[DPHASE_W-1:0]      = w_rom_data;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a same-note match ends the scan immediately, a free
    // slot is only taken once the full scan has ruled out a retrigger
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SEARCH;
            ST_SEARCH: begin
                if (w_cur_match)  w_next = ST_LOOKUP;
                else if (w_last)  w_next = w_hit_free ? ST_LOOKUP : ST_IDLE;
            end
            ST_LOOKUP: w_next = ST_PEND;
            ST_PEND:   if (upd_grant) w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ev_ready = (r_state == ST_IDLE) && !reset;
        ram_we   = (r_state == ST_WRITE);
    end

    // Event latch, scan bookkeeping, RAM output registers, voice busy flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note_on     <= 1'b0;
            r_note        <= '0;
            r_wave        <= '0;
            r_idx         <= '0;
            r_sel         <= '0;
            r_free        <= '0;
            r_have_free   <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_overflow    <= 1'b0;
            r_busy        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_note_on   <= ev_note_on;
                        r_note      <= ev_note;
                        r_wave      <= ev_wave;
                        r_idx       <= '0;
                        r_have_free <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_note_on && !w_cur_busy && !r_have_free) begin
                        r_have_free <= 1'b1;
                        r_free      <= r_idx;
                    end
                    if (w_cur_match) begin
                        r_sel <= r_idx;
                    end else if (w_last) begin
                        r_sel <= r_have_free ? r_free : r_idx;
                        if (r_note_on && !w_hit_free) r_overflow <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (upd_grant) begin
                        r_ram_address <= ADDR_W'(r_sel);
                        r_ram_data    <= w_word;
                    end
                end
                ST_WRITE: r_busy[r_sel] <= r_note_on;
                default: ;
            endcase
        end
    end

    // Per-voice note numbers; only meaningful while the busy flag is set
    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE && r_note_on) r_vnote[r_sel] <= r_note;
    end

    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign overflow    = r_overflow;

endmodule
